// File: rtl/al_accel_pkg.sv
// Shared constants, types and helpers for the accelerator element-wise unit.
// Imported by the requantize channel and the element-wise top.
package al_accel_pkg;

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned PROD_W  = 64;
    localparam int unsigned INT8_W  = 8;
    localparam int unsigned SHIFT_W = 8;
    localparam int unsigned ACT_W   = 4;
    localparam int unsigned SH_W    = 5;

    localparam logic signed [INT8_W-1:0] INT8_MIN  = 8'sh80;
    localparam logic signed [INT8_W-1:0] INT8_MAX  = 8'sh7F;
    localparam logic signed [ACC_W-1:0]  ACC_MIN   = 32'sh8000_0000;
    localparam logic signed [ACC_W-1:0]  ACC_MAX   = 32'sh7FFF_FFFF;
    localparam logic signed [PROD_W-1:0] Q31_ROUND = 64'sh0000_0000_4000_0000;

    typedef enum logic [ACT_W-1:0] {
        ACT_NONE = 4'd0,
        ACT_RELU = 4'd1
    } act_typ_e;

    // Per-sample configuration carried alongside the data through the pipe
    typedef struct packed {
        logic [SHIFT_W-1:0]      rshift;
        logic signed [ACC_W-1:0] offset;
        logic                    relu;
    } quant_cfg_t;

    function automatic logic signed [INT8_W-1:0] max_s8(
        input logic signed [INT8_W-1:0] a,
        input logic signed [INT8_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/al_accel_quant_act.sv
// One requantize + activation channel: Q31 high multiply, rounding shift,
// offset and int8 clamp, fully pipelined with a valid flag per stage.
module al_accel_quant_act
    import al_accel_pkg::*;
#(
    parameter int unsigned QUANT_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic signed [ACC_W-1:0]  di,
    input  logic signed [ACC_W-1:0]  muler,
    input  logic [SHIFT_W-1:0]       rshift,
    input  logic signed [ACC_W-1:0]  offset,
    input  logic [ACT_W-1:0]         act_typ,
    output logic                     rdy,
    output logic signed [INT8_W-1:0] dout
);

    localparam int unsigned EXTRA = (QUANT_LAT > 3) ? (QUANT_LAT - 3) : 0;
    localparam logic signed [ACC_W:0] V_MIN = (ACC_W+1)'(INT8_MIN);
    localparam logic signed [ACC_W:0] V_MAX = (ACC_W+1)'(INT8_MAX);

    // Stage 1: full 64-bit product, plus the one input pair that overflows the doubling
    logic signed [PROD_W-1:0] prod_c;
    logic                     ovf_c;
    quant_cfg_t               cfg_c;

    assign prod_c = PROD_W'(di) * PROD_W'(muler);
    assign ovf_c  = (di == ACC_MIN) && (muler == ACC_MIN);
    assign cfg_c  = '{rshift: rshift, offset: offset, relu: (act_typ == ACT_RELU)};

    logic                     s1_vld;
    logic signed [PROD_W-1:0] s1_prod;
    logic                     s1_ovf;
    quant_cfg_t               s1_cfg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_prod <= '0;
            s1_ovf  <= 1'b0;
            s1_cfg  <= '0;
        end else begin
            s1_vld <= enb;
            if (enb) begin
                s1_prod <= prod_c;
                s1_ovf  <= ovf_c;
                s1_cfg  <= cfg_c;
            end
        end
    end

    // Stage 2: rounding doubling high multiply
    logic signed [PROD_W-1:0] rnd_c;
    logic signed [ACC_W-1:0]  h_c;

    assign rnd_c = (s1_prod + Q31_ROUND) >>> 31;
    assign h_c   = s1_ovf ? ACC_MAX : ACC_W'(rnd_c);

    logic                    s2_vld;
    logic signed [ACC_W-1:0] s2_h;
    quant_cfg_t              s2_cfg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_h   <= '0;
            s2_cfg <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_h   <= h_c;
                s2_cfg <= s1_cfg;
            end
        end
    end

    // Stage 3: divide by 2^s rounding half away from zero
    logic [SH_W-1:0]         sh_c;
    logic [ACC_W-1:0]        mask_c;
    logic [ACC_W-1:0]        rem_c;
    logic [ACC_W-1:0]        thr_c;
    logic signed [ACC_W-1:0] shr_c;
    logic signed [ACC_W-1:0] q_c;

    assign sh_c   = (s2_cfg.rshift > SHIFT_W'(31)) ? SH_W'(31) : s2_cfg.rshift[SH_W-1:0];
    assign mask_c = (ACC_W'(1'b1) << sh_c) - ACC_W'(1'b1);
    assign rem_c  = s2_h & mask_c;
    assign thr_c  = (mask_c >> 1) + ACC_W'(s2_h[ACC_W-1]);
    // kept separate so the arithmetic shift is not turned unsigned by the rounding term
    assign shr_c  = s2_h >>> sh_c;
    assign q_c    = shr_c + ACC_W'(rem_c > thr_c);

    logic                    s3_vld;
    logic signed [ACC_W-1:0] s3_q;
    quant_cfg_t              s3_cfg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_vld <= 1'b0;
            s3_q   <= '0;
            s3_cfg <= '0;
        end else begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_q   <= q_c;
                s3_cfg <= s2_cfg;
            end
        end
    end

    // Offset, activation lower bound and int8 saturation
    logic signed [ACC_W:0]        v_c;
    logic signed [ACC_W:0]        off_c;
    logic signed [ACC_W:0]        lo_c;
    logic signed [ACC_W:0]        t_c;
    logic signed [INT8_W-1:0]     res_c;

    assign v_c   = (ACC_W+1)'(s3_q) + (ACC_W+1)'(s3_cfg.offset);
    assign off_c = (ACC_W+1)'(s3_cfg.offset);
    assign lo_c  = (s3_cfg.relu && (off_c > V_MIN)) ? off_c : V_MIN;
    assign t_c   = (v_c < lo_c) ? lo_c : v_c;
    assign res_c = (t_c > V_MAX) ? INT8_MAX : INT8_W'(t_c);

    logic                     fin_vld;
    logic signed [INT8_W-1:0] fin_res;

    generate
        if (EXTRA == 0) begin : g_no_dly
            assign fin_vld = s3_vld;
            assign fin_res = res_c;
        end else begin : g_dly
            // Padding stages for latencies beyond the core datapath depth
            logic                     dly_vld [EXTRA];
            logic signed [INT8_W-1:0] dly_res [EXTRA];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < EXTRA; i++) begin
                        dly_vld[i] <= 1'b0;
                        dly_res[i] <= '0;
                    end
                end else begin
                    dly_vld[0] <= s3_vld;
                    dly_res[0] <= res_c;
                    for (int unsigned i = 1; i < EXTRA; i++) begin
                        dly_vld[i] <= dly_vld[i-1];
                        dly_res[i] <= dly_res[i-1];
                    end
                end
            end

            assign fin_vld = dly_vld[EXTRA-1];
            assign fin_res = dly_res[EXTRA-1];
        end
    endgenerate

    // Output register: one rdy pulse per sample, data held between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy  <= 1'b0;
            dout <= '0;
        end else begin
            rdy <= fin_vld;
            if (fin_vld) begin
                dout <= fin_res;
            end
        end
    end

endmodule

// File: rtl/al_accel_elw_unit.sv
// Element-wise post-processing: three requantize/activation channels and a
// running-max compare register for max pooling.
module al_accel_elw_unit
    import al_accel_pkg::*;
#(
    parameter int unsigned QUANT_LAT = 3,
    parameter logic [7:0]  CP_INIT   = 8'h80
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic signed [ACC_W-1:0]  elew_di_0_0,
    input  logic signed [ACC_W-1:0]  elew_di_0_1,
    input  logic signed [ACC_W-1:0]  elew_di_0_2,
    input  logic signed [INT8_W-1:0] elew_di_1_0,
    input  logic signed [INT8_W-1:0] elew_di_1_1,
    input  logic signed [INT8_W-1:0] elew_di_1_2,
    output logic signed [INT8_W-1:0] elew_do_0_0,
    output logic signed [INT8_W-1:0] elew_do_0_1,
    output logic signed [INT8_W-1:0] elew_do_0_2,
    output logic signed [INT8_W-1:0] elew_do_1,
    input  logic signed [ACC_W-1:0]  elew_quant_muler_0,
    input  logic signed [ACC_W-1:0]  elew_quant_muler_1,
    input  logic signed [ACC_W-1:0]  elew_quant_muler_2,
    input  logic [SHIFT_W-1:0]       elew_quant_rshift_0,
    input  logic [SHIFT_W-1:0]       elew_quant_rshift_1,
    input  logic [SHIFT_W-1:0]       elew_quant_rshift_2,
    input  logic signed [ACC_W-1:0]  elew_output_offset,
    input  logic [ACT_W-1:0]         elew_act_func_typ,
    input  logic                     quant_act_func_enb_0,
    input  logic                     quant_act_func_enb_1,
    input  logic                     quant_act_func_enb_2,
    output logic                     quant_act_func_rdy_0,
    output logic                     quant_act_func_rdy_1,
    output logic                     quant_act_func_rdy_2,
    input  logic                     cp_clr,
    input  logic                     cp2h_enb,
    input  logic                     cp2w_enb,
    input  logic                     cp_enb
);

    al_accel_quant_act #(.QUANT_LAT(QUANT_LAT)) u_quant_0 (
        .clk     (clk),
        .rst     (resetn),
        .enb     (quant_act_func_enb_0),
        .di      (elew_di_0_0),
        .muler   (elew_quant_muler_0),
        .rshift  (elew_quant_rshift_0),
        .offset  (elew_output_offset),
        .act_typ (elew_act_func_typ),
        .rdy     (quant_act_func_rdy_0),
        .dout    (elew_do_0_0)
    );

    al_accel_quant_act #(.QUANT_LAT(QUANT_LAT)) u_quant_1 (
        .clk     (clk),
        .rst     (resetn),
        .enb     (quant_act_func_enb_1),
        .di      (elew_di_0_1),
        .muler   (elew_quant_muler_1),
        .rshift  (elew_quant_rshift_1),
        .offset  (elew_output_offset),
        .act_typ (elew_act_func_typ),
        .rdy     (quant_act_func_rdy_1),
        .dout    (elew_do_0_1)
    );

    al_accel_quant_act #(.QUANT_LAT(QUANT_LAT)) u_quant_2 (
        .clk     (clk),
        .rst     (resetn),
        .enb     (quant_act_func_enb_2),
        .di      (elew_di_0_2),
        .muler   (elew_quant_muler_2),
        .rshift  (elew_quant_rshift_2),
        .offset  (elew_output_offset),
        .act_typ (elew_act_func_typ),
        .rdy     (quant_act_func_rdy_2),
        .dout    (elew_do_0_2)
    );

    // Running max; disabled window positions compete as -128 so they never win
    logic signed [INT8_W-1:0] cp_max_q;
    logic signed [INT8_W-1:0] cand_w_c;
    logic signed [INT8_W-1:0] cand_h_c;
    logic signed [INT8_W-1:0] cp_next_c;

    always_comb begin
        cand_w_c  = INT8_MIN;
        cand_h_c  = INT8_MIN;
        if (cp2w_enb) begin
            cand_w_c = elew_di_1_1;
        end
        if (cp2h_enb) begin
            cand_h_c = elew_di_1_2;
        end
        cp_next_c = max_s8(max_s8(cp_max_q, elew_di_1_0), max_s8(cand_w_c, cand_h_c));
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cp_max_q <= CP_INIT;
        end else if (cp_clr) begin
            cp_max_q <= CP_INIT;
        end else if (cp_enb) begin
            cp_max_q <= cp_next_c;
        end
    end

    assign elew_do_1 = cp_max_q;

endmodule

// File: tb/tb_al_accel_elw_unit.sv
// Self-checking bench for al_accel_elw_unit: vector table and random traffic
// through a per-channel scoreboard, plus compare-unit and reset sequences.
module tb_al_accel_elw_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetn = 1'b1;
    logic signed [31:0] elew_di_0_0 = '0, elew_di_0_1 = '0, elew_di_0_2 = '0;
    logic signed [7:0]  elew_di_1_0 = '0, elew_di_1_1 = '0, elew_di_1_2 = '0;
    logic signed [7:0]  elew_do_0_0, elew_do_0_1, elew_do_0_2, elew_do_1;
    logic signed [31:0] elew_quant_muler_0 = '0, elew_quant_muler_1 = '0, elew_quant_muler_2 = '0;
    logic [7:0]         elew_quant_rshift_0 = '0, elew_quant_rshift_1 = '0, elew_quant_rshift_2 = '0;
    logic signed [31:0] elew_output_offset = '0;
    logic [3:0]         elew_act_func_typ = '0;
    logic               quant_act_func_enb_0 = 1'b0, quant_act_func_enb_1 = 1'b0, quant_act_func_enb_2 = 1'b0;
    logic               quant_act_func_rdy_0, quant_act_func_rdy_1, quant_act_func_rdy_2;
    logic               cp_clr = 1'b0, cp2h_enb = 1'b0, cp2w_enb = 1'b0, cp_enb = 1'b0;

    al_accel_elw_unit #(.QUANT_LAT(3), .CP_INIT(8'h80)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .elew_di_0_0          (elew_di_0_0),
        .elew_di_0_1          (elew_di_0_1),
        .elew_di_0_2          (elew_di_0_2),
        .elew_di_1_0          (elew_di_1_0),
        .elew_di_1_1          (elew_di_1_1),
        .elew_di_1_2          (elew_di_1_2),
        .elew_do_0_0          (elew_do_0_0),
        .elew_do_0_1          (elew_do_0_1),
        .elew_do_0_2          (elew_do_0_2),
        .elew_do_1            (elew_do_1),
        .elew_quant_muler_0   (elew_quant_muler_0),
        .elew_quant_muler_1   (elew_quant_muler_1),
        .elew_quant_muler_2   (elew_quant_muler_2),
        .elew_quant_rshift_0  (elew_quant_rshift_0),
        .elew_quant_rshift_1  (elew_quant_rshift_1),
        .elew_quant_rshift_2  (elew_quant_rshift_2),
        .elew_output_offset   (elew_output_offset),
        .elew_act_func_typ    (elew_act_func_typ),
        .quant_act_func_enb_0 (quant_act_func_enb_0),
        .quant_act_func_enb_1 (quant_act_func_enb_1),
        .quant_act_func_enb_2 (quant_act_func_enb_2),
        .quant_act_func_rdy_0 (quant_act_func_rdy_0),
        .quant_act_func_rdy_1 (quant_act_func_rdy_1),
        .quant_act_func_rdy_2 (quant_act_func_rdy_2),
        .cp_clr               (cp_clr),
        .cp2h_enb             (cp2h_enb),
        .cp2w_enb             (cp2w_enb),
        .cp_enb               (cp_enb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: round-half-away-from-zero division, plain clamp
    function automatic logic signed [7:0] model(input logic signed [31:0] x, input logic signed [31:0] m,
                                                 input logic [7:0] sh, input logic signed [31:0] off,
                                                 input logic [3:0] act);
        longint p, h, q, v, lo;
        int s;
        if (x == 32'sh80000000 && m == 32'sh80000000) h = 64'sh7FFFFFFF;
        else begin
            p = longint'(x) * longint'(m);
            h = (p + 64'sd1073741824) >>> 31;
        end
        s = (sh > 8'd31) ? 31 : int'(sh);
        if (s == 0) q = h;
        else if (h >= 0) q = (h + (longint'(1) << (s - 1))) >>> s;
        else q = -(((-h) + (longint'(1) << (s - 1))) >>> s);
        v  = q + longint'(off);
        lo = (act == 4'd1 && off > -128) ? longint'(off) : -128;
        if (v < lo) v = lo;
        if (v > 127) v = 127;
        return 8'(v);
    endfunction

    // Scoreboard: expected data and the negedge cycle at which rdy must show it
    typedef struct {
        logic signed [7:0] data;
        int unsigned       due;
    } exp_t;

    exp_t        sbq [3][$];
    int unsigned cyc = 0;
    logic        mon_en = 1'b0;
    logic signed [7:0] last_v [3];
    logic [2:0]        rdy_v;
    logic signed [7:0] do_v [3];

    assign rdy_v   = {quant_act_func_rdy_2, quant_act_func_rdy_1, quant_act_func_rdy_0};
    assign do_v[0] = elew_do_0_0;
    assign do_v[1] = elew_do_0_1;
    assign do_v[2] = elew_do_0_2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            for (int c = 0; c < 3; c++) begin
                if (rdy_v[c]) begin
                    if (sbq[c].size() == 0) begin
                        chk($sformatf("ch%0d_spurious_rdy", c), 1, 0);
                    end else begin
                        e = sbq[c].pop_front();
                        chk($sformatf("ch%0d_data", c), do_v[c], e.data);
                        chk($sformatf("ch%0d_latency_cycle", c), cyc, e.due);
                        last_v[c] = e.data;
                    end
                end else begin
                    chk($sformatf("ch%0d_hold", c), do_v[c], last_v[c]);
                    if (sbq[c].size() > 0 && sbq[c][0].due < cyc) begin
                        e = sbq[c].pop_front();
                        chk($sformatf("ch%0d_rdy_missing_due", c), cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic set_ch(input int c, input logic e, input logic signed [31:0] x,
                          input logic signed [31:0] m, input logic [7:0] sh);
        case (c)
            0: begin quant_act_func_enb_0 = e; elew_di_0_0 = x; elew_quant_muler_0 = m; elew_quant_rshift_0 = sh; end
            1: begin quant_act_func_enb_1 = e; elew_di_0_1 = x; elew_quant_muler_1 = m; elew_quant_rshift_1 = sh; end
            default: begin quant_act_func_enb_2 = e; elew_di_0_2 = x; elew_quant_muler_2 = m; elew_quant_rshift_2 = sh; end
        endcase
    endtask

    task automatic expect_out(input int c, input logic signed [7:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 4;
        sbq[c].push_back(e);
    endtask

    task automatic idle_enb();
        quant_act_func_enb_0 = 1'b0;
        quant_act_func_enb_1 = 1'b0;
        quant_act_func_enb_2 = 1'b0;
    endtask

    task automatic cp_step(input string name, input logic clr, input logic en, input logic w, input logic h,
                           input logic signed [7:0] a, input logic signed [7:0] b, input logic signed [7:0] c,
                           input logic signed [7:0] exp);
        @(posedge clk); #1;
        cp_clr = clr; cp_enb = en; cp2w_enb = w; cp2h_enb = h;
        elew_di_1_0 = a; elew_di_1_1 = b; elew_di_1_2 = c;
        @(posedge clk);
        @(negedge clk);
        chk(name, elew_do_1, exp);
        cp_clr = 1'b0; cp_enb = 1'b0;
    endtask

    typedef struct {
        int                 ch;
        logic signed [31:0] x;
        logic signed [31:0] m;
        logic [7:0]         sh;
        logic signed [31:0] off;
        logic [3:0]         act;
        logic signed [7:0]  exp;
    } vec_t;

    vec_t vecs [$];

    initial begin : main
        vec_t v;
        int   pend;
        logic signed [31:0] rx, rm, roff;
        logic [7:0]         rsh;
        logic [3:0]         ract;
        logic               ren;

        vecs.push_back('{0, 32'sd4581,       32'sd2039693188, 8'd8,  32'sd0,    4'd0,  8'sd17});
        vecs.push_back('{1, 32'sh00020000,   32'sh19921576,   8'd7,  32'sd0,    4'd0,  8'sd127});
        vecs.push_back('{2, 32'sh00030000,   32'sh19921576,   8'd7,  32'sd0,    4'd0,  8'sd127});
        vecs.push_back('{0, -32'sd4581,      32'sd2039693188, 8'd8,  32'sd0,    4'd0, -8'sd17});
        vecs.push_back('{0, -32'sd4581,      32'sd2039693188, 8'd8,  32'sd0,    4'd1,  8'sd0});
        vecs.push_back('{0, -32'sd4581,      32'sd2039693188, 8'd8,  32'sd5,    4'd1,  8'sd5});
        vecs.push_back('{1, 32'sh80000000,   32'sh80000000,   8'd0,  32'sd0,    4'd0,  8'sd127});
        vecs.push_back('{2, 32'sd4581,       32'sd2039693188, 8'd8,  32'sd0,    4'd7,  8'sd17});
        vecs.push_back('{0, -32'sd4581,      32'sd2039693188, 8'd8, -32'sd200,  4'd0, -8'sd128});
        vecs.push_back('{1, 32'sd4581,       32'sd2039693188, 8'd40, 32'sd3,    4'd0,  8'sd3});
        vecs.push_back('{2, 32'sh80000000,   32'sh80000000,   8'd31, 32'sd0,    4'd0,  8'sd1});
        vecs.push_back('{0, 32'sh80000000,   32'sh7FFFFFFF,   8'd0,  32'sd0,    4'd0, -8'sd128});
        vecs.push_back('{1, 32'sd1,          32'sh40000000,   8'd1,  32'sd0,    4'd0,  8'sd1});
        vecs.push_back('{2, -32'sd3,         32'sh40000000,   8'd1,  32'sd0,    4'd0, -8'sd1});
        vecs.push_back('{0, -32'sd4581,      32'sd2039693188, 8'd8, -32'sd300,  4'd1, -8'sd128});

        for (int c = 0; c < 3; c++) last_v[c] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_do_0_0", elew_do_0_0, 0);
        chk("reset_do_0_1", elew_do_0_1, 0);
        chk("reset_do_0_2", elew_do_0_2, 0);
        chk("reset_rdy", rdy_v, 0);
        chk("reset_do_1", elew_do_1, -128);
        resetn = 1'b0;
        mon_en = 1'b1;

        // Vector table, applied back to back
        foreach (vecs[i]) begin
            v = vecs[i];
            @(posedge clk); #1;
            idle_enb();
            elew_output_offset = v.off;
            elew_act_func_typ  = v.act;
            set_ch(v.ch, 1'b1, v.x, v.m, v.sh);
            expect_out(v.ch, v.exp);
        end
        @(posedge clk); #1;
        idle_enb();
        repeat (6) @(posedge clk);

        // Overflow corner pulsed three cycles in a row on one channel
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            elew_output_offset = 32'sd0;
            elew_act_func_typ  = 4'd0;
            set_ch(0, 1'b1, 32'sh80000000, 32'sh80000000, 8'd0);
            expect_out(0, 8'sd127);
        end
        @(posedge clk); #1;
        idle_enb();
        repeat (6) @(posedge clk);

        // Random traffic, all channels active together
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            roff = 32'($urandom_range(300)) - 32'sd150;
            ract = 4'($urandom_range(2));
            elew_output_offset = roff;
            elew_act_func_typ  = ract;
            for (int c = 0; c < 3; c++) begin
                ren = 1'($urandom_range(1));
                rx  = 32'($urandom) >>> $urandom_range(20);
                rm  = 32'($urandom);
                rsh = 8'($urandom_range(40));
                set_ch(c, ren, rx, rm, rsh);
                if (ren) expect_out(c, model(rx, rm, rsh, roff, ract));
            end
        end
        @(posedge clk); #1;
        idle_enb();

        // Compare unit, running concurrently with the channel drain
        cp_step("cp_first_max",     1'b0, 1'b1, 1'b1, 1'b1,  8'sd10,  8'sd20,  8'sd15,  8'sd20);
        cp_step("cp_smaller_hold",  1'b0, 1'b1, 1'b1, 1'b1, -8'sd5,  -8'sd3,  -8'sd1,   8'sd20);
        cp_step("cp_idle_hold",     1'b0, 1'b0, 1'b1, 1'b1,  8'sd100, 8'sd100, 8'sd100, 8'sd20);
        cp_step("cp_clr_priority",  1'b1, 1'b1, 1'b1, 1'b1,  8'sd90,  8'sd90,  8'sd90, -8'sd128);
        cp_step("cp_w_masked",      1'b0, 1'b1, 1'b0, 1'b1,  8'sd10,  8'sd50,  8'sd15,  8'sd15);
        cp_step("cp_clr_again",     1'b1, 1'b0, 1'b0, 1'b0,  8'sd0,   8'sd0,   8'sd0,  -8'sd128);
        cp_step("cp_h_w_masked",    1'b0, 1'b1, 1'b0, 1'b0, -8'sd100, 8'sd60,  8'sd70, -8'sd100);
        cp_step("cp_h_only",        1'b0, 1'b1, 1'b0, 1'b1, -8'sd120, 8'sd60, -8'sd90, -8'sd90);

        // Drain with a bounded wait
        for (int i = 0; i < 20; i++) begin
            pend = sbq[0].size() + sbq[1].size() + sbq[2].size();
            if (pend == 0) break;
            @(posedge clk);
        end
        chk("drain_pending", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);

        // Asynchronous reset with samples in flight
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            elew_output_offset = 32'sd0;
            elew_act_func_typ  = 4'd0;
            for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 32'sd4581, 32'sd2039693188, 8'd8);
        end
        @(posedge clk); #1;
        idle_enb();
        #2;
        mon_en = 1'b0;
        resetn = 1'b1;
        #1;
        chk("midrst_do_0_0", elew_do_0_0, 0);
        chk("midrst_do_0_1", elew_do_0_1, 0);
        chk("midrst_do_0_2", elew_do_0_2, 0);
        chk("midrst_rdy", rdy_v, 0);
        chk("midrst_do_1", elew_do_1, -128);
        for (int c = 0; c < 3; c++) begin
            sbq[c].delete();
            last_v[c] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        mon_en = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("post_rst_do_1", elew_do_1, -128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
